cipher_word_packer: RTL and testbench

- Downstream stage of the byte-serial stream cipher. Consumes its 8-bit output bytes (dout/dout_valid) and its message-boundary strobe (key_in).
- Packs bytes little-endian into 32-bit words with byte-keep and last markers.
- Buffers words in a small FIFO and presents them on a valid/ready word interface toward the bus/DMA side.
- The cipher has no backpressure, so this block absorbs stalls and flags loss.

---
 rtl/cipher_word_packer_pkg.sv | 26 ++
 rtl/cipher_word_packer_if.sv | 13 +
 rtl/cipher_word_packer_word_fifo.sv | 52 +++++
 rtl/cipher_word_packer.sv | 82 ++++++++
 tb/tb_cipher_word_packer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cipher_word_packer_pkg.sv
// Shared types for the cipher output word packer: word/keep types, the FIFO
// entry layout and the assembly FSM states.
package cipher_pkg;

    localparam int WORD_BYTES = 4;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  keep_t;

    typedef struct packed {
        word_t data;
        keep_t keep;
        logic  last;
    } fifo_entry_t;

    typedef enum logic [1:0] {IDLE, FILL, HELD} pack_state_t;

    // Insert one byte into the given little-endian lane of a word.
    function automatic word_t put_byte(word_t w, logic [1:0] lane, logic [7:0] b);
        word_t r;
        r = w;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/cipher_word_packer_if.sv
// Word-side valid/ready bus between the packer (master) and the bus/DMA consumer.
interface cipher_word_packer_if import cipher_pkg::*; ();

    word_t word_out;
    keep_t word_keep;
    logic  word_last;
    logic  word_valid;
    logic  word_ready;

    modport master (output word_out, word_keep, word_last, word_valid, input word_ready);
    modport slave  (input word_out, word_keep, word_last, word_valid, output word_ready);

endinterface

// File: rtl/cipher_word_packer_word_fifo.sv
// First-word-fall-through FIFO of packed word entries; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module word_fifo import cipher_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fifo_entry_t            push_data,
    input  logic                   pop,
    output fifo_entry_t            head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          pop_ok;
    logic          push_ok;

    // Extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cipher_word_packer.sv
// Packs cipher output bytes little-endian into 32-bit words with keep/last
// markers and buffers them in a FWFT FIFO; drops and flags words on overflow.
module cipher_word_packer import cipher_pkg::*; #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  din,
    input  logic                        din_valid,
    input  logic                        flush,
    cipher_word_packer_if.master        wb,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    pack_state_t state;
    logic [1:0]  cnt;
    word_t       asm_data;
    keep_t       asm_keep;
    logic        push;
    fifo_entry_t push_entry;
    fifo_entry_t head;
    logic        fifo_empty;
    logic        fifo_full;
    logic        drop;

    // A full word waits in HELD so a following flush can still tag it last.
    assign push       = (flush && state != IDLE) || (din_valid && !flush && state == HELD);
    assign push_entry = '{data: asm_data, keep: asm_keep, last: flush};
    // When full the FIFO is non-empty, so a pop happens exactly when ready is high.
    assign drop       = push && fifo_full && !wb.word_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            asm_data <= '0;
            asm_keep <= '0;
        end else if (flush || (din_valid && state != FILL)) begin
            // Start of a fresh word: either after a flush or after the held word left.
            if (din_valid) begin
                asm_data <= put_byte('0, 2'd0, din);
                asm_keep <= 4'b0001;
                cnt      <= 2'd1;
                state    <= FILL;
            end else begin
                asm_data <= '0;
                asm_keep <= '0;
                cnt      <= '0;
                state    <= IDLE;
            end
        end else if (din_valid) begin
            asm_data      <= put_byte(asm_data, cnt, din);
            asm_keep[cnt] <= 1'b1;
            cnt           <= cnt + 1'b1;
            if (cnt == 2'd3) state <= HELD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

    word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (wb.word_ready),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    assign wb.word_out   = head.data;
    assign wb.word_keep  = head.keep;
    assign wb.word_last  = head.last;
    assign wb.word_valid = !fifo_empty;

endmodule

// File: tb/tb_cipher_word_packer.sv
// Directed scoreboard bench for cipher_word_packer: expected words are queued
// as stimulus is driven and compared as the consumer pops them.
module tb_cipher_word_packer;
    import cipher_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] fifo_level;
    logic       overflow;

    cipher_word_packer_if bus ();

    cipher_word_packer #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .flush      (flush),
        .wb         (bus),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    fifo_entry_t q[$];
    int          errors = 0;
    int          checks = 0;
    word_t       last_word = '0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(logic [7:0] b, logic v, logic f);
        din = b;
        din_valid = v;
        flush = f;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_w(word_t d, keep_t k, logic l);
        fifo_entry_t e;
        e.data = d;
        e.keep = k;
        e.last = l;
        q.push_back(e);
    endtask

    task automatic drain(string tag);
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_words_left"}, q.size(), 0);
        idle(2);
    endtask

    // Consumer-side scoreboard: a word is popped at the edge following this sample.
    always @(negedge clk) begin
        if (rst_n && bus.word_valid && bus.word_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_word", bus.word_valid, 1'b0);
            end else begin
                fifo_entry_t e;
                e = q.pop_front();
                chk("word", {bus.word_out, bus.word_keep, bus.word_last}, e);
                last_word = bus.word_out;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.word_ready = 1'b0;
        #3;
        chk("rst_valid", bus.word_valid, 1'b0);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_word", bus.word_out, 32'h0);
        chk("rst_keep", bus.word_keep, 4'h0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // flush while IDLE straight after reset
        cyc(8'h00, 1'b0, 1'b1);
        idle(2);
        chk("t3a_valid", bus.word_valid, 1'b0);
        chk("t3a_level", fifo_level, 3'd0);

        // five bytes then flush
        bus.word_ready = 1'b1;
        expect_w(32'h44332211, 4'hF, 1'b0);
        expect_w(32'h00000055, 4'h1, 1'b1);
        cyc(8'h11, 1'b1, 1'b0);
        cyc(8'h22, 1'b1, 1'b0);
        cyc(8'h33, 1'b1, 1'b0);
        cyc(8'h44, 1'b1, 1'b0);
        cyc(8'h55, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b1);
        drain("t1");
        chk("t1_overflow", overflow, 1'b0);
        chk("t1_level", fifo_level, 3'd0);

        // exactly four bytes then flush marks the held word last
        expect_w(32'hD4C3B2A1, 4'hF, 1'b1);
        cyc(8'hA1, 1'b1, 1'b0);
        cyc(8'hB2, 1'b1, 1'b0);
        cyc(8'hC3, 1'b1, 1'b0);
        cyc(8'hD4, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b1);
        drain("t2");
        chk("t2_no_more", bus.word_valid, 1'b0);

        // flush in IDLE right after a completed message
        cyc(8'h00, 1'b0, 1'b1);
        idle(2);
        chk("t3b_valid", bus.word_valid, 1'b0);
        chk("t3b_level", fifo_level, 3'd0);

        // flush coinciding with a byte: byte starts the next message
        expect_w(32'h0000BBAA, 4'h3, 1'b1);
        expect_w(32'h000000CC, 4'h1, 1'b1);
        cyc(8'hAA, 1'b1, 1'b0);
        cyc(8'hBB, 1'b1, 1'b0);
        cyc(8'hCC, 1'b1, 1'b1);
        cyc(8'h00, 1'b0, 1'b1);
        drain("t4");

        // stall: six words into a four-deep FIFO
        bus.word_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            word_t w;
            w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            expect_w(w, 4'hF, 1'b0);
        end
        for (int i = 0; i < 24; i++) begin
            cyc(8'(i), 1'b1, 1'b0);
            if (bus.word_valid) chk("t5_head_stable", bus.word_out, 32'h03020100);
        end
        cyc(8'h00, 1'b0, 1'b1);
        idle(2);
        chk("t5_level", fifo_level, 3'd4);
        chk("t5_overflow", overflow, 1'b1);
        chk("t5_head", bus.word_out, 32'h03020100);
        chk("t5_head_keep", bus.word_keep, 4'hF);
        chk("t5_head_last", bus.word_last, 1'b0);
        bus.word_ready = 1'b1;
        drain("t5");
        chk("t5_last_popped", last_word, 32'h0F0E0D0C);
        chk("t5_level_empty", fifo_level, 3'd0);
        chk("t5_overflow_sticky", overflow, 1'b1);

        // asynchronous reset mid-cycle with data buffered and a partial word
        bus.word_ready = 1'b0;
        for (int i = 0; i < 9; i++) cyc(8'h40 + 8'(i), 1'b1, 1'b0);
        chk("t6_pre_level", fifo_level, 3'd2);
        chk("t6_pre_overflow", overflow, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_valid", bus.word_valid, 1'b0);
        chk("t6_level", fifo_level, 3'd0);
        chk("t6_overflow", overflow, 1'b0);
        chk("t6_word", bus.word_out, 32'h0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.word_ready = 1'b1;
        cyc(8'h00, 1'b0, 1'b1);
        idle(3);
        chk("t6_flush_valid", bus.word_valid, 1'b0);
        chk("t6_flush_level", fifo_level, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
